// File: rtl/pipe_pkg.sv
// Shared pipeline types for the ID/EX stage: control bundle,
// ALU op-class encodings and register-zero / bubble constants.
package pipe_pkg;

   localparam logic [1:0] ALUOP_ADD    = 2'b00;
   localparam logic [1:0] ALUOP_BRANCH = 2'b01;
   localparam logic [1:0] ALUOP_RTYPE  = 2'b10;
   localparam logic [1:0] ALUOP_ITYPE  = 2'b11;

   localparam int unsigned REG_ZERO = 0;

   typedef struct packed {
      logic       regwrite;
      logic       memread;
      logic       memwrite;
      logic       memtoreg;
      logic       branch;
      logic       alusrc;
      logic [1:0] aluop;
      logic [3:0] funct;
   } idex_ctrl_t;

   localparam idex_ctrl_t BUBBLE_CTRL = '0;

endpackage

// File: rtl/hazard_detect.sv
// Combinational load-use hazard detection and PC / IF-ID write enables.
// A taken-branch flush overrides a load-use stall so the PC takes the target.
module hazard_detect
   import pipe_pkg::*;
#(
   parameter int REGW = 5
) (
   input  logic            idex_valid,
   input  logic            idex_memread,
   input  logic [REGW-1:0] idex_rd,
   input  logic            id_valid,
   input  logic [REGW-1:0] id_rs1,
   input  logic [REGW-1:0] id_rs2,
   input  logic            ex_branch_taken,
   input  logic            ext_stall,
   output logic            load_use_stall,
   output logic            pc_write,
   output logic            ifid_write
);

   logic rd_match;

   assign rd_match = (idex_rd == id_rs1) | (idex_rd == id_rs2);

   assign load_use_stall = idex_valid & idex_memread
                         & (idex_rd != REGW'(REG_ZERO))
                         & id_valid & rd_match;

   assign pc_write   = ~ext_stall & (~load_use_stall | ex_branch_taken);
   assign ifid_write = pc_write;

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble and flush insertion.
// Define ID_EX_STALL_CNT_EN to add saturating bubble counters.
module id_ex_stage
   import pipe_pkg::*;
#(
   parameter int XLEN = 64,
   parameter int REGW = 5
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            id_valid,
   input  logic [REGW-1:0] id_rs1,
   input  logic [REGW-1:0] id_rs2,
   input  logic [REGW-1:0] id_rd,
   input  logic [XLEN-1:0] id_rs1_data,
   input  logic [XLEN-1:0] id_rs2_data,
   input  logic [XLEN-1:0] id_imm,
   input  logic [XLEN-1:0] id_pc,
   input  logic            id_regwrite,
   input  logic            id_memread,
   input  logic            id_memwrite,
   input  logic            id_memtoreg,
   input  logic            id_branch,
   input  logic            id_alusrc,
   input  logic [1:0]      id_aluop,
   input  logic [3:0]      id_funct,
   input  logic            ex_branch_taken,
   input  logic            ext_stall,
   output logic            idex_valid,
   output logic [REGW-1:0] idex_rs1,
   output logic [REGW-1:0] idex_rs2,
   output logic [REGW-1:0] idex_rd,
   output logic [XLEN-1:0] idex_rs1_data,
   output logic [XLEN-1:0] idex_rs2_data,
   output logic [XLEN-1:0] idex_imm,
   output logic [XLEN-1:0] idex_pc,
   output logic            idex_regwrite,
   output logic            idex_memread,
   output logic            idex_memwrite,
   output logic            idex_memtoreg,
   output logic            idex_branch,
   output logic            idex_alusrc,
   output logic [1:0]      idex_aluop,
   output logic [3:0]      idex_funct,
   output logic            pc_write,
   output logic            ifid_write,
   output logic            load_use_stall
`ifdef ID_EX_STALL_CNT_EN
   ,
   output logic [31:0]     lu_bubble_cnt,
   output logic [31:0]     flush_bubble_cnt
`endif
);

   logic            valid_q, valid_d;
   logic [REGW-1:0] rs1_q, rs1_d;
   logic [REGW-1:0] rs2_q, rs2_d;
   logic [REGW-1:0] rd_q, rd_d;
   logic [XLEN-1:0] rs1_data_q, rs1_data_d;
   logic [XLEN-1:0] rs2_data_q, rs2_data_d;
   logic [XLEN-1:0] imm_q, imm_d;
   logic [XLEN-1:0] pc_q, pc_d;
   idex_ctrl_t      ctrl_q, ctrl_d;
   idex_ctrl_t      id_ctrl;
   logic            bubble;

   hazard_detect #(.REGW(REGW)) u_hazard (
      .idex_valid      (valid_q),
      .idex_memread    (ctrl_q.memread),
      .idex_rd         (rd_q),
      .id_valid        (id_valid),
      .id_rs1          (id_rs1),
      .id_rs2          (id_rs2),
      .ex_branch_taken (ex_branch_taken),
      .ext_stall       (ext_stall),
      .load_use_stall  (load_use_stall),
      .pc_write        (pc_write),
      .ifid_write      (ifid_write)
   );

   assign bubble = ex_branch_taken | load_use_stall;

   always_comb begin
      id_ctrl          = BUBBLE_CTRL;
      id_ctrl.regwrite = id_regwrite & id_valid;
      id_ctrl.memread  = id_memread  & id_valid;
      id_ctrl.memwrite = id_memwrite & id_valid;
      id_ctrl.memtoreg = id_memtoreg & id_valid;
      id_ctrl.branch   = id_branch   & id_valid;
      id_ctrl.alusrc   = id_alusrc   & id_valid;
      id_ctrl.aluop    = id_aluop;
      id_ctrl.funct    = id_funct;
   end

   always_comb begin
      valid_d    = valid_q;
      rs1_d      = rs1_q;
      rs2_d      = rs2_q;
      rd_d       = rd_q;
      rs1_data_d = rs1_data_q;
      rs2_data_d = rs2_data_q;
      imm_d      = imm_q;
      pc_d       = pc_q;
      ctrl_d     = ctrl_q;
      if (ext_stall) begin
         valid_d = valid_q;
      end else if (bubble) begin
         // Zeroed indices keep forwarding from matching on a bubble.
         valid_d    = 1'b0;
         rs1_d      = '0;
         rs2_d      = '0;
         rd_d       = '0;
         rs1_data_d = '0;
         rs2_data_d = '0;
         imm_d      = '0;
         pc_d       = '0;
         ctrl_d     = BUBBLE_CTRL;
      end else begin
         valid_d    = id_valid;
         rs1_d      = id_rs1;
         rs2_d      = id_rs2;
         rd_d       = id_rd;
         rs1_data_d = id_rs1_data;
         rs2_data_d = id_rs2_data;
         imm_d      = id_imm;
         pc_d       = id_pc;
         ctrl_d     = id_ctrl;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         valid_q    <= 1'b0;
         rs1_q      <= '0;
         rs2_q      <= '0;
         rd_q       <= '0;
         rs1_data_q <= '0;
         rs2_data_q <= '0;
         imm_q      <= '0;
         pc_q       <= '0;
         ctrl_q     <= BUBBLE_CTRL;
      end else begin
         valid_q    <= valid_d;
         rs1_q      <= rs1_d;
         rs2_q      <= rs2_d;
         rd_q       <= rd_d;
         rs1_data_q <= rs1_data_d;
         rs2_data_q <= rs2_data_d;
         imm_q      <= imm_d;
         pc_q       <= pc_d;
         ctrl_q     <= ctrl_d;
      end
   end

   assign idex_valid    = valid_q;
   assign idex_rs1      = rs1_q;
   assign idex_rs2      = rs2_q;
   assign idex_rd       = rd_q;
   assign idex_rs1_data = rs1_data_q;
   assign idex_rs2_data = rs2_data_q;
   assign idex_imm      = imm_q;
   assign idex_pc       = pc_q;
   assign idex_regwrite = ctrl_q.regwrite;
   assign idex_memread  = ctrl_q.memread;
   assign idex_memwrite = ctrl_q.memwrite;
   assign idex_memtoreg = ctrl_q.memtoreg;
   assign idex_branch   = ctrl_q.branch;
   assign idex_alusrc   = ctrl_q.alusrc;
   assign idex_aluop    = ctrl_q.aluop;
   assign idex_funct    = ctrl_q.funct;

`ifdef ID_EX_STALL_CNT_EN
   logic [31:0] lu_cnt_q, lu_cnt_d;
   logic [31:0] fl_cnt_q, fl_cnt_d;

   // A flush takes credit for a bubble even when a load-use is also pending.
   always_comb begin
      lu_cnt_d = lu_cnt_q;
      fl_cnt_d = fl_cnt_q;
      if (!ext_stall && ex_branch_taken) begin
         if (fl_cnt_q != '1) fl_cnt_d = fl_cnt_q + 32'd1;
      end else if (!ext_stall && load_use_stall) begin
         if (lu_cnt_q != '1) lu_cnt_d = lu_cnt_q + 32'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         lu_cnt_q <= '0;
         fl_cnt_q <= '0;
      end else begin
         lu_cnt_q <= lu_cnt_d;
         fl_cnt_q <= fl_cnt_d;
      end
   end

   assign lu_bubble_cnt    = lu_cnt_q;
   assign flush_bubble_cnt = fl_cnt_q;
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed scenarios then random
// traffic against a per-edge behavioural model of the EX-side latch.
module tb_id_ex_stage;

   logic        clk = 1'b0;
   logic        reset;
   logic        id_valid;
   logic [4:0]  id_rs1, id_rs2, id_rd;
   logic [63:0] id_rs1_data, id_rs2_data, id_imm, id_pc;
   logic        id_regwrite, id_memread, id_memwrite;
   logic        id_memtoreg, id_branch, id_alusrc;
   logic [1:0]  id_aluop;
   logic [3:0]  id_funct;
   logic        ex_branch_taken, ext_stall;
   logic        idex_valid;
   logic [4:0]  idex_rs1, idex_rs2, idex_rd;
   logic [63:0] idex_rs1_data, idex_rs2_data, idex_imm, idex_pc;
   logic        idex_regwrite, idex_memread, idex_memwrite;
   logic        idex_memtoreg, idex_branch, idex_alusrc;
   logic [1:0]  idex_aluop;
   logic [3:0]  idex_funct;
   logic        pc_write, ifid_write, load_use_stall;
`ifdef ID_EX_STALL_CNT_EN
   logic [31:0] lu_bubble_cnt, flush_bubble_cnt;
`endif

   always #5 clk = ~clk;

   id_ex_stage dut (
      .clk(clk), .reset(reset), .id_valid(id_valid),
      .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
      .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
      .id_imm(id_imm), .id_pc(id_pc),
      .id_regwrite(id_regwrite), .id_memread(id_memread),
      .id_memwrite(id_memwrite), .id_memtoreg(id_memtoreg),
      .id_branch(id_branch), .id_alusrc(id_alusrc),
      .id_aluop(id_aluop), .id_funct(id_funct),
      .ex_branch_taken(ex_branch_taken), .ext_stall(ext_stall),
      .idex_valid(idex_valid),
      .idex_rs1(idex_rs1), .idex_rs2(idex_rs2), .idex_rd(idex_rd),
      .idex_rs1_data(idex_rs1_data), .idex_rs2_data(idex_rs2_data),
      .idex_imm(idex_imm), .idex_pc(idex_pc),
      .idex_regwrite(idex_regwrite), .idex_memread(idex_memread),
      .idex_memwrite(idex_memwrite), .idex_memtoreg(idex_memtoreg),
      .idex_branch(idex_branch), .idex_alusrc(idex_alusrc),
      .idex_aluop(idex_aluop), .idex_funct(idex_funct),
      .pc_write(pc_write), .ifid_write(ifid_write),
      .load_use_stall(load_use_stall)
`ifdef ID_EX_STALL_CNT_EN
      ,
      .lu_bubble_cnt(lu_bubble_cnt),
      .flush_bubble_cnt(flush_bubble_cnt)
`endif
   );

   typedef struct packed {
      logic        valid;
      logic [4:0]  rs1, rs2, rd;
      logic [63:0] d1, d2, imm, pc;
      logic        regwrite, memread, memwrite, memtoreg, branch, alusrc;
      logic [1:0]  aluop;
      logic [3:0]  funct;
   } ex_t;

   ex_t         m;
   logic [31:0] m_lu, m_fl;
   int          checks = 0;
   int          failures = 0;

   task automatic chk(input string tag, input logic [283:0] obs,
                      input logic [283:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic ex_t dut_view();
      return {idex_valid, idex_rs1, idex_rs2, idex_rd,
              idex_rs1_data, idex_rs2_data, idex_imm, idex_pc,
              idex_regwrite, idex_memread, idex_memwrite,
              idex_memtoreg, idex_branch, idex_alusrc,
              idex_aluop, idex_funct};
   endfunction

   // What EX would hold if ID's instruction were accepted.
   function automatic ex_t from_id();
      ex_t e;
      e.valid    = id_valid;
      e.rs1      = id_rs1;
      e.rs2      = id_rs2;
      e.rd       = id_rd;
      e.d1       = id_rs1_data;
      e.d2       = id_rs2_data;
      e.imm      = id_imm;
      e.pc       = id_pc;
      e.regwrite = id_regwrite && id_valid;
      e.memread  = id_memread && id_valid;
      e.memwrite = id_memwrite && id_valid;
      e.memtoreg = id_memtoreg && id_valid;
      e.branch   = id_branch && id_valid;
      e.alusrc   = id_alusrc && id_valid;
      e.aluop    = id_aluop;
      e.funct    = id_funct;
      return e;
   endfunction

   function automatic logic model_hazard();
      return m.valid && m.memread && m.rd != 0 && id_valid
             && (m.rd == id_rs1 || m.rd == id_rs2);
   endfunction

   task automatic set_id(input logic v, input logic [4:0] r1,
                         input logic [4:0] r2, input logic [4:0] rd,
                         input logic mr, input logic rw);
      id_valid    = v;
      id_rs1      = r1;
      id_rs2      = r2;
      id_rd       = rd;
      id_memread  = mr;
      id_regwrite = rw;
      id_rs1_data = {$urandom, $urandom};
      id_rs2_data = {$urandom, $urandom};
      id_imm      = {$urandom, $urandom};
      id_pc       = {$urandom, $urandom};
      id_memwrite = 1'($urandom);
      id_memtoreg = mr;
      id_branch   = 1'($urandom);
      id_alusrc   = 1'($urandom);
      id_aluop    = 2'($urandom);
      id_funct    = 4'($urandom);
   endtask

   // Inputs already applied; check comb outputs, clock, check state.
   task automatic cycle(input string tag);
      logic haz, pcw;
      ex_t  nx;
      #1;
      haz = model_hazard();
      pcw = !ext_stall && (!haz || ex_branch_taken);
      if (!reset) begin
         chk({tag, "_lus"}, 284'(load_use_stall), 284'(haz));
         chk({tag, "_pcw"}, 284'(pc_write), 284'(pcw));
         chk({tag, "_ifw"}, 284'(ifid_write), 284'(pcw));
      end
      if (reset) nx = '0;
      else if (ext_stall) nx = m;
      else if (ex_branch_taken || haz) nx = '0;
      else nx = from_id();
      if (reset) begin
         m_lu = 0;
         m_fl = 0;
      end else if (!ext_stall && ex_branch_taken) begin
         if (m_fl != 32'hFFFF_FFFF) m_fl++;
      end else if (!ext_stall && haz) begin
         if (m_lu != 32'hFFFF_FFFF) m_lu++;
      end
      @(posedge clk);
      #1;
      m = nx;
      chk({tag, "_st"}, 284'(dut_view()), 284'(m));
`ifdef ID_EX_STALL_CNT_EN
      chk({tag, "_lucnt"}, 284'(lu_bubble_cnt), 284'(m_lu));
      chk({tag, "_flcnt"}, 284'(flush_bubble_cnt), 284'(m_fl));
`endif
   endtask

   initial begin
      reset = 1'b1;
      ex_branch_taken = 1'b0;
      ext_stall = 1'b0;
      set_id(1'b1, 5'd1, 5'd2, 5'd3, 1'b1, 1'b1);
      @(posedge clk);
      #1;
      m = '0;
      m_lu = 0;
      m_fl = 0;
      cycle("reset");
      chk("reset_valid", 284'(idex_valid), 284'(0));

      reset = 1'b0;
      set_id(1'b1, 5'd0, 5'd0, 5'd5, 1'b0, 1'b1);
      id_rs1_data = 64'h11;
      cycle("cap");
      chk("cap_rd", 284'(idex_rd), 284'(5));
      chk("cap_d1", 284'(idex_rs1_data), 284'(64'h11));
      chk("cap_v", 284'(idex_valid), 284'(1));

      set_id(1'b1, 5'd1, 5'd2, 5'd7, 1'b1, 1'b1);
      cycle("ld7");
      set_id(1'b1, 5'd3, 5'd7, 5'd9, 1'b0, 1'b1);
      #1;
      chk("lu_flag", 284'(load_use_stall), 284'(1));
      chk("lu_pcw", 284'(pc_write), 284'(0));
      cycle("lu");
      chk("lu_bub_rd", 284'(idex_rd), 284'(0));
      chk("lu_bub_rw", 284'(idex_regwrite), 284'(0));
      cycle("lu_after");
      chk("lu_after_rs2", 284'(idex_rs2), 284'(7));
      chk("lu_after_v", 284'(idex_valid), 284'(1));

      set_id(1'b1, 5'd1, 5'd2, 5'd0, 1'b1, 1'b1);
      cycle("ld0");
      set_id(1'b1, 5'd0, 5'd4, 5'd6, 1'b0, 1'b1);
      #1;
      chk("x0_flag", 284'(load_use_stall), 284'(0));
      cycle("x0");
      chk("x0_rd", 284'(idex_rd), 284'(6));

      set_id(1'b1, 5'd1, 5'd2, 5'd7, 1'b1, 1'b1);
      cycle("ld7b");
      set_id(1'b1, 5'd7, 5'd2, 5'd8, 1'b0, 1'b1);
      ex_branch_taken = 1'b1;
      #1;
      chk("fl_lus", 284'(load_use_stall), 284'(1));
      chk("fl_pcw", 284'(pc_write), 284'(1));
      cycle("flush");
      chk("fl_v", 284'(idex_valid), 284'(0));

      ex_branch_taken = 1'b0;
      set_id(1'b1, 5'd4, 5'd5, 5'd12, 1'b0, 1'b1);
      cycle("pre_frz");
      ext_stall = 1'b1;
      ex_branch_taken = 1'b1;
      for (int i = 0; i < 3; i++) begin
         set_id(1'b1, 5'd1, 5'd1, 5'd1, 1'b0, 1'b1);
         #1;
         chk("frz_pcw", 284'(pc_write), 284'(0));
         cycle("frz");
         chk("frz_rd", 284'(idex_rd), 284'(12));
      end
      ext_stall = 1'b0;
      cycle("frz_rel");
      chk("frz_rel_v", 284'(idex_valid), 284'(0));

      ex_branch_taken = 1'b0;
      set_id(1'b1, 5'd1, 5'd2, 5'd7, 1'b1, 1'b1);
      cycle("ld7c");
      set_id(1'b1, 5'd7, 5'd7, 5'd3, 1'b0, 1'b1);
      #1;
      chk("rst_lus_pre", 284'(load_use_stall), 284'(1));
      reset = 1'b1;
      cycle("rst_mid");
      reset = 1'b0;
      #1;
      chk("rst_lus_post", 284'(load_use_stall), 284'(0));

      for (int i = 0; i < 400; i++) begin
         reset = ($urandom_range(0, 49) == 0);
         ext_stall = ($urandom_range(0, 7) == 0);
         ex_branch_taken = ($urandom_range(0, 7) == 0);
         set_id(1'($urandom_range(0, 5) != 0),
                5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                5'($urandom_range(0, 3)), 1'($urandom),
                1'($urandom));
         cycle("rnd");
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
